// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller at the consumer side of the ID/EX register.
//   Detects load-use hazards (stalling for LOAD_LAT cycles), sequences the
//   flush window after a taken branch (FLUSH_CYCLES cycles), and generates the
//   EX-stage operand forwarding selects.
//
// Parameters
//   LOAD_LAT      stall cycles inserted per load-use hazard (1..7)
//   FLUSH_CYCLES  cycles IF/ID and ID/EX are flushed after a taken branch (1..7)
//
// Ports
//   CLOCK, RESET_N            clock (rising edge), async active-low reset
//   IF_ID_*_In                source registers of the instruction in ID
//   ID_EX_*_In                sources, destination and control of EX instr
//   EX_MEM_* / MEM_WB_*       destination and write enable of MEM / WB instr
//   BranchTaken_In            branch resolved taken this cycle
//   PCWriteEN_Out             PC may update
//   IF_ID_WriteEN_Out         IF/ID may load
//   IF_ID_Flush_Out           IF/ID loads a NOP
//   ID_EX_Bubble_Out          ID/EX loads zeroed control bits
//   FwdASEL_Out, FwdBSEL_Out  00 regfile, 01 MEM/WB, 10 EX/MEM
//
// Optional build macro HAZARD_PERF_EN
//   Adds StallCnt_Out / FlushCnt_Out, saturating 32-bit counters of stalled
//   and flushed cycles.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [4:0] IF_ID_RSAddr_In,
    input  logic [4:0] IF_ID_RTAddr_In,
    input  logic       IF_ID_UsesRT_In,
    input  logic [4:0] ID_EX_RSAddr_In,
    input  logic [4:0] ID_EX_RTAddr_In,
    input  logic [4:0] ID_EX_DstAddr_In,
    input  logic       ID_EX_RegWriteEN_In,
    input  logic       ID_EX_Mem2RegSEL_In,
    input  logic [4:0] EX_MEM_DstAddr_In,
    input  logic       EX_MEM_RegWriteEN_In,
    input  logic [4:0] MEM_WB_DstAddr_In,
    input  logic       MEM_WB_RegWriteEN_In,
    input  logic       BranchTaken_In,
`ifdef HAZARD_PERF_EN
    output logic [31:0] StallCnt_Out,
    output logic [31:0] FlushCnt_Out,
`endif
    output logic       PCWriteEN_Out,
    output logic       IF_ID_WriteEN_Out,
    output logic       IF_ID_Flush_Out,
    output logic       ID_EX_Bubble_Out,
    output logic [1:0] FwdASEL_Out,
    output logic [1:0] FwdBSEL_Out
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_r, state_next_s;
    logic [2:0] cnt_r, cnt_next_s;
    logic       load_haz_s;
    logic       pc_we_s, ifid_we_s, ifid_flush_s, idex_bubble_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    // Forwarding select: EX/MEM has priority, register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_dst,
        input logic       mem_we,
        input logic [4:0] wb_dst,
        input logic       wb_we
    );
        logic [1:0] sel;
        if (mem_we && (mem_dst != 5'd0) && (mem_dst == src)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_dst != 5'd0) && (wb_dst == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load-use hazard: EX holds a load whose destination the ID instruction reads.
    always_comb begin
        load_haz_s = ID_EX_RegWriteEN_In && ID_EX_Mem2RegSEL_In &&
                     (ID_EX_DstAddr_In != 5'd0) &&
                     ((ID_EX_DstAddr_In == IF_ID_RSAddr_In) ||
                      (IF_ID_UsesRT_In && (ID_EX_DstAddr_In == IF_ID_RTAddr_In)));
    end

    // State and counter register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; a taken branch always wins over load stalling.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (BranchTaken_In) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_next_s = ST_BR_FLUSH;
                        cnt_next_s   = FLUSH_RELOAD;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else if (load_haz_s) begin
                    if (LOAD_LAT > 1) begin
                        state_next_s = ST_LD_STALL;
                        cnt_next_s   = LOAD_RELOAD;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_LD_STALL: begin
                if (BranchTaken_In) begin
                    cnt_next_s   = FLUSH_RELOAD;
                    state_next_s = (FLUSH_CYCLES > 1) ? ST_BR_FLUSH : ST_RUN;
                end else if (cnt_r == 3'd1) begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = 3'd0;
                end else begin
                    cnt_next_s   = cnt_r - 3'd1;
                end
            end
            ST_BR_FLUSH: begin
                // Hazards are ignored: the instruction in ID is being flushed.
                if (BranchTaken_In) begin
                    cnt_next_s = FLUSH_RELOAD;
                end else if (cnt_r == 3'd1) begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = 3'd0;
                end else begin
                    cnt_next_s   = cnt_r - 3'd1;
                end
            end
            default: begin
                state_next_s = ST_RUN;
                cnt_next_s   = 3'd0;
            end
        endcase
    end

    // Output decode; reset overrides asynchronously with the safe values.
    always_comb begin
        pc_we_s       = 1'b1;
        ifid_we_s     = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        fwd_a_s = fwd_sel(ID_EX_RSAddr_In, EX_MEM_DstAddr_In, EX_MEM_RegWriteEN_In,
                          MEM_WB_DstAddr_In, MEM_WB_RegWriteEN_In);
        fwd_b_s = fwd_sel(ID_EX_RTAddr_In, EX_MEM_DstAddr_In, EX_MEM_RegWriteEN_In,
                          MEM_WB_DstAddr_In, MEM_WB_RegWriteEN_In);
        if (!RESET_N) begin
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            fwd_a_s       = 2'b00;
            fwd_b_s       = 2'b00;
        end else begin
            case (state_r)
                ST_RUN, ST_LD_STALL: begin
                    if (BranchTaken_In) begin
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else if (load_haz_s || (state_r == ST_LD_STALL)) begin
                        pc_we_s       = 1'b0;
                        ifid_we_s     = 1'b0;
                        idex_bubble_s = 1'b1;
                    end else begin
                        idex_bubble_s = 1'b0;
                    end
                end
                ST_BR_FLUSH: begin
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end
                default: begin
                    idex_bubble_s = 1'b1;
                end
            endcase
        end
    end

    assign PCWriteEN_Out     = pc_we_s;
    assign IF_ID_WriteEN_Out = ifid_we_s;
    assign IF_ID_Flush_Out   = ifid_flush_s;
    assign ID_EX_Bubble_Out  = idex_bubble_s;
    assign FwdASEL_Out       = fwd_a_s;
    assign FwdBSEL_Out       = fwd_b_s;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_r, flush_cnt_r;

    // Saturating counters of stalled and flushed cycles.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (!pc_we_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign StallCnt_Out = stall_cnt_r;
    assign FlushCnt_Out = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Two instances share one stimulus: dut_a (LOAD_LAT=3, FLUSH_CYCLES=2) and
//   dut_b (LOAD_LAT=1, FLUSH_CYCLES=1). Inputs are driven 1 time unit after the
//   rising edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    typedef struct {
        logic [4:0] rs_id;
        logic [4:0] rt_id;
        logic       uses_rt;
        logic [4:0] rs_ex;
        logic [4:0] rt_ex;
        logic [4:0] dst_ex;
        logic       rw_ex;
        logic       ld_ex;
        logic [4:0] dst_mem;
        logic       rw_mem;
        logic [4:0] dst_wb;
        logic       rw_wb;
        logic       br;
        logic [7:0] exp; // {pcw, ifw, flush, bubble, fwdA[1:0], fwdB[1:0]}
    } vec_t;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, dst_ex, dst_mem, dst_wb;
    logic       uses_rt, rw_ex, ld_ex, rw_mem, rw_wb, br;

    logic       a_pcw, a_ifw, a_fl, a_bub, b_pcw, b_ifw, b_fl, b_bub;
    logic [1:0] a_fa, a_fb, b_fa, b_fb;
    logic [7:0] a_out, b_out;
`ifdef HAZARD_PERF_EN
    logic [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vecs[13];
    vec_t idle;

    assign a_out = {a_pcw, a_ifw, a_fl, a_bub, a_fa, a_fb};
    assign b_out = {b_pcw, b_ifw, b_fl, b_bub, b_fa, b_fb};

    always #5 CLOCK = ~CLOCK;

    hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2)) dut_a (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .IF_ID_RSAddr_In(rs_id), .IF_ID_RTAddr_In(rt_id), .IF_ID_UsesRT_In(uses_rt),
        .ID_EX_RSAddr_In(rs_ex), .ID_EX_RTAddr_In(rt_ex), .ID_EX_DstAddr_In(dst_ex),
        .ID_EX_RegWriteEN_In(rw_ex), .ID_EX_Mem2RegSEL_In(ld_ex),
        .EX_MEM_DstAddr_In(dst_mem), .EX_MEM_RegWriteEN_In(rw_mem),
        .MEM_WB_DstAddr_In(dst_wb), .MEM_WB_RegWriteEN_In(rw_wb),
        .BranchTaken_In(br),
`ifdef HAZARD_PERF_EN
        .StallCnt_Out(a_stall), .FlushCnt_Out(a_flush),
`endif
        .PCWriteEN_Out(a_pcw), .IF_ID_WriteEN_Out(a_ifw), .IF_ID_Flush_Out(a_fl),
        .ID_EX_Bubble_Out(a_bub), .FwdASEL_Out(a_fa), .FwdBSEL_Out(a_fb)
    );

    hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1)) dut_b (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .IF_ID_RSAddr_In(rs_id), .IF_ID_RTAddr_In(rt_id), .IF_ID_UsesRT_In(uses_rt),
        .ID_EX_RSAddr_In(rs_ex), .ID_EX_RTAddr_In(rt_ex), .ID_EX_DstAddr_In(dst_ex),
        .ID_EX_RegWriteEN_In(rw_ex), .ID_EX_Mem2RegSEL_In(ld_ex),
        .EX_MEM_DstAddr_In(dst_mem), .EX_MEM_RegWriteEN_In(rw_mem),
        .MEM_WB_DstAddr_In(dst_wb), .MEM_WB_RegWriteEN_In(rw_wb),
        .BranchTaken_In(br),
`ifdef HAZARD_PERF_EN
        .StallCnt_Out(b_stall), .FlushCnt_Out(b_flush),
`endif
        .PCWriteEN_Out(b_pcw), .IF_ID_WriteEN_Out(b_ifw), .IF_ID_Flush_Out(b_fl),
        .ID_EX_Bubble_Out(b_bub), .FwdASEL_Out(b_fa), .FwdBSEL_Out(b_fb)
    );

    task automatic apply(input vec_t v);
        rs_id = v.rs_id;   rt_id = v.rt_id;   uses_rt = v.uses_rt;
        rs_ex = v.rs_ex;   rt_ex = v.rt_ex;   dst_ex = v.dst_ex;
        rw_ex = v.rw_ex;   ld_ex = v.ld_ex;
        dst_mem = v.dst_mem; rw_mem = v.rw_mem;
        dst_wb = v.dst_wb;   rw_wb = v.rw_wb;
        br = v.br;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, then to the sampling point.
    task automatic next_drive();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLOCK);
    endtask

    initial begin
        vec_t v;
        //              rsid  rtid  urt   rsex  rtex  dsex  rwx   ldx   dmem  rwm   dwb   rww   br    {pcw,ifw,fl,bub,fa,fb}
        idle     = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'b1100_0000};
        vecs[0]  = idle;
        vecs[1]  = '{5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'b0001_0000};
        vecs[2]  = '{5'd1, 5'd8, 1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'b0001_0000};
        vecs[3]  = '{5'd1, 5'd8, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'b1100_0000};
        vecs[4]  = '{5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'b1100_0000};
        vecs[5]  = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 8'b1100_0000};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 8'b1100_0010};
        vecs[7]  = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 8'b1100_0001};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 8'b1100_1001};
        vecs[9]  = '{5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'b1100_0000};
        vecs[10] = '{5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'b1100_0000};
        vecs[11] = '{5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 8'b1111_0000};
        vecs[12] = '{5'd1, 5'd7, 1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'b1100_0000};

        // Reset state, with forwarding-matching inputs to show the override.
        v = vecs[8];
        apply(v);
        #2;
        chk("reset_a", {24'd0, a_out}, {24'd0, 8'b0011_0000});
        chk("reset_b", {24'd0, b_out}, {24'd0, 8'b0011_0000});
        apply(idle);
        sample();
        RESET_N = 1'b1;
        next_drive();

        // Single-cycle vectors from RUN; idle afterwards lets every window drain.
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            sample();
            chk($sformatf("vec%0d_a", i), {24'd0, a_out}, {24'd0, vecs[i].exp});
            chk($sformatf("vec%0d_b", i), {24'd0, b_out}, {24'd0, vecs[i].exp});
            next_drive();
            apply(idle);
            repeat (4) next_drive();
        end

        // Load-use held for one cycle: dut_a stalls 3 cycles, dut_b 1 cycle.
        apply(vecs[2]);
        sample();
        chk("ld3_c0_a", {31'd0, a_pcw}, 32'd0);
        chk("ld1_c0_b", {31'd0, b_pcw}, 32'd0);
        next_drive();
        apply(idle);
        sample();
        chk("ld3_c1_a", {24'd0, a_out}, {24'd0, 8'b0001_0000});
        chk("ld1_c1_b", {24'd0, b_out}, {24'd0, 8'b1100_0000});
        next_drive();
        sample();
        chk("ld3_c2_a", {31'd0, a_pcw}, 32'd0);
        next_drive();
        sample();
        chk("ld3_c3_a", {24'd0, a_out}, {24'd0, 8'b1100_0000});
        repeat (3) next_drive();

        // Branch coincident with load hazard; hazard stays visible a cycle more.
        apply(vecs[11]);
        sample();
        chk("br_c0_a", {24'd0, a_out}, {24'd0, 8'b1111_0000});
        next_drive();
        v = vecs[11];
        v.br = 1'b0;
        apply(v);
        sample();
        chk("br_c1_a", {24'd0, a_out}, {24'd0, 8'b1111_0000});
        chk("br_c1_b", {24'd0, b_out}, {24'd0, 8'b0001_0000});
        next_drive();
        apply(idle);
        sample();
        chk("br_c2_a", {24'd0, a_out}, {24'd0, 8'b1100_0000});
        chk("br_c2_b", {24'd0, b_out}, {24'd0, 8'b1100_0000});
        repeat (4) next_drive();

        // Branch arriving during a load stall converts it into a flush window.
        apply(vecs[1]);
        next_drive();
        v = idle;
        v.br = 1'b1;
        apply(v);
        sample();
        chk("ldbr_c1_a", {24'd0, a_out}, {24'd0, 8'b1111_0000});
        next_drive();
        apply(idle);
        sample();
        chk("ldbr_c2_a", {24'd0, a_out}, {24'd0, 8'b1111_0000});
        next_drive();
        sample();
        chk("ldbr_c3_a", {24'd0, a_out}, {24'd0, 8'b1100_0000});
        repeat (4) next_drive();

        // Reset pulse during the second cycle of a 3-cycle stall.
        apply(vecs[1]);
        next_drive();
        v = idle;
        v.rs_ex = 5'd3; v.dst_mem = 5'd3; v.rw_mem = 1'b1;
        apply(v);
        sample();
        chk("rst_pre_a", {24'd0, a_out}, {24'd0, 8'b0001_1000});
        #1;
        RESET_N = 1'b0;
        #1;
        chk("rst_async_a", {24'd0, a_out}, {24'd0, 8'b0011_0000});
`ifdef HAZARD_PERF_EN
        chk("rst_stallcnt_a", a_stall, 32'd0);
        chk("rst_flushcnt_a", a_flush, 32'd0);
`endif
        @(posedge CLOCK);
        #2;
        RESET_N = 1'b1;
        apply(idle);
        sample();
        chk("rst_post_a", {24'd0, a_out}, {24'd0, 8'b1100_0000});
        next_drive();
        sample();
        chk("rst_post2_a", {24'd0, a_out}, {24'd0, 8'b1100_0000});
`ifdef HAZARD_PERF_EN
        chk("post_stallcnt_a", a_stall, 32'd0);
        // One stall cycle on dut_b, then the counter must show exactly one.
        next_drive();
        apply(vecs[1]);
        next_drive();
        apply(idle);
        sample();
        chk("perf_stallcnt_b", b_stall, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
